hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_mem_wait_timer.sv | 45 ++++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW          = 5;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned WAIT_W          = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(0);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller; the pipeline is master, the controller slave.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_AW-1:0] D_rs1_i;
  logic [REG_AW-1:0] D_rs2_i;
  logic              D_use_rs1_i;
  logic              D_use_rs2_i;
  logic              DD_load_i;
  logic [REG_AW-1:0] DD_dstE_i;
  logic              E_jmp_sel_i;
  logic              ED_mem_req_i;
  logic              dmem_ready_i;

  logic              PC_stall_o;
  logic              F_stall_o;
  logic              D_stall_o;
  logic              E_stall_o;
  logic              F_bubble_o;
  logic              D_bubble_o;
  logic              M_bubble_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic              mem_timeout_o;

  modport master (
    output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, DD_load_i, DD_dstE_i,
           E_jmp_sel_i, ED_mem_req_i, dmem_ready_i,
    input  PC_stall_o, F_stall_o, D_stall_o, E_stall_o,
           F_bubble_o, D_bubble_o, M_bubble_o,
           stall_cnt_o, flush_cnt_o, mem_timeout_o
  );

  modport slave (
    input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, DD_load_i, DD_dstE_i,
           E_jmp_sel_i, ED_mem_req_i, dmem_ready_i,
    output PC_stall_o, F_stall_o, D_stall_o, E_stall_o,
           F_bubble_o, D_bubble_o, M_bubble_o,
           stall_cnt_o, flush_cnt_o, mem_timeout_o
  );

endinterface

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Memory-wait cycle counter with sticky timeout flag.
module mem_wait_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst,
  input  logic enter_i,
  input  logic in_wait_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_nxt;
  logic              timeout_q;

  // Clear on entry to the wait, count each waiting cycle, saturate at the limit.
  always_comb begin
    cnt_nxt = cnt_q;
    if (enter_i) begin
      cnt_nxt = '0;
    end else if (in_wait_i && (cnt_q != LIMIT)) begin
      cnt_nxt = cnt_q + WAIT_W'(1);
    end
  end

  // Counter register and sticky flag; the flag sets as the count reaches the limit.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      if (in_wait_i && (cnt_nxt == LIMIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, redirect flush and load-use interlock.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  hz_state_e        state_q;
  logic             mem_stall;
  logic             load_hit;
  logic             redirect;
  logic             lu_stall;
  logic             pc_stall, f_stall, d_stall, e_stall;
  logic             f_bubble, d_bubble, m_bubble;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             mem_timeout;

  // Hazard detection and prioritised stall/bubble decode (memory > redirect > load-use).
  always_comb begin
    pc_stall = 1'b0;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    f_bubble = 1'b0;
    d_bubble = 1'b0;
    m_bubble = 1'b0;
    redirect = 1'b0;
    lu_stall = 1'b0;

    if (state_q == ST_RUN) begin
      mem_stall = bus.ED_mem_req_i && !bus.dmem_ready_i;
    end else begin
      mem_stall = !bus.dmem_ready_i;
    end

    load_hit = bus.DD_load_i && (bus.DD_dstE_i != ZERO_REG) &&
               ((bus.D_use_rs1_i && (bus.D_rs1_i == bus.DD_dstE_i)) ||
                (bus.D_use_rs2_i && (bus.D_rs2_i == bus.DD_dstE_i)));

    if (rst) begin
      f_bubble = 1'b1;
      d_bubble = 1'b1;
      m_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_bubble = 1'b1;
    end else if (bus.E_jmp_sel_i) begin
      redirect = 1'b1;
      f_bubble = 1'b1;
      d_bubble = 1'b1;
    end else if (load_hit) begin
      lu_stall = 1'b1;
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_bubble = 1'b1;
    end
  end

  // RUN/MWAIT state register.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (bus.ED_mem_req_i && !bus.dmem_ready_i) state_q <= ST_MWAIT;
        ST_MWAIT: if (bus.dmem_ready_i) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Lost-cycle and redirect counters, free-running modulo 2^32.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (mem_stall || lu_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect)              flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst       (rst),
    .enter_i   ((state_q == ST_RUN) && mem_stall),
    .in_wait_i (state_q == ST_MWAIT),
    .timeout_o (mem_timeout)
  );

  assign bus.PC_stall_o    = pc_stall;
  assign bus.F_stall_o     = f_stall;
  assign bus.D_stall_o     = d_stall;
  assign bus.E_stall_o     = e_stall;
  assign bus.F_bubble_o    = f_bubble;
  assign bus.D_bubble_o    = d_bubble;
  assign bus.M_bubble_o    = m_bubble;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.flush_cnt_o   = flush_cnt_q;
  assign bus.mem_timeout_o = mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default-TIMEOUT and TIMEOUT=4 instances share stimulus.
module tb_hazard_ctrl;

  // Control word: {PC_stall, F_stall, D_stall, E_stall, F_bubble, D_bubble, M_bubble}
  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_RD   = 7'b0000110;
  localparam logic [6:0] C_MS   = 7'b1111001;
  localparam logic [6:0] C_RST  = 7'b0000111;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       ld;
    logic [4:0] dst;
    logic       jmp;
    logic       mreq;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;

  hazard_ctrl_if bus ();
  hazard_ctrl_if bus4 ();

  hazard_ctrl dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  hazard_ctrl #(.TIMEOUT(4)) dut4 (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus4)
  );

  assign bus4.D_rs1_i      = bus.D_rs1_i;
  assign bus4.D_rs2_i      = bus.D_rs2_i;
  assign bus4.D_use_rs1_i  = bus.D_use_rs1_i;
  assign bus4.D_use_rs2_i  = bus.D_use_rs2_i;
  assign bus4.DD_load_i    = bus.DD_load_i;
  assign bus4.DD_dstE_i    = bus.DD_dstE_i;
  assign bus4.E_jmp_sel_i  = bus.E_jmp_sel_i;
  assign bus4.ED_mem_req_i = bus.ED_mem_req_i;
  assign bus4.dmem_ready_i = bus.dmem_ready_i;

  always #5 clk_i = ~clk_i;

  wire logic [6:0] ctl  = {bus.PC_stall_o, bus.F_stall_o, bus.D_stall_o, bus.E_stall_o,
                           bus.F_bubble_o, bus.D_bubble_o, bus.M_bubble_o};
  wire logic [6:0] ctl4 = {bus4.PC_stall_o, bus4.F_stall_o, bus4.D_stall_o, bus4.E_stall_o,
                           bus4.F_bubble_o, bus4.D_bubble_o, bus4.M_bubble_o};

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;
  logic        exp_to  = 1'b0;
  logic        exp_to4 = 1'b0;
  vec_t        vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                     input logic use2, input logic ld, input logic [4:0] dst,
                     input logic jmp, input logic mreq, input logic rdy);
    bus.D_rs1_i      = rs1;
    bus.D_rs2_i      = rs2;
    bus.D_use_rs1_i  = use1;
    bus.D_use_rs2_i  = use2;
    bus.DD_load_i    = ld;
    bus.DD_dstE_i    = dst;
    bus.E_jmp_sel_i  = jmp;
    bus.ED_mem_req_i = mreq;
    bus.dmem_ready_i = rdy;
  endtask

  task automatic drive_vec(input vec_t v);
    drv(v.rs1, v.rs2, v.use1, v.use2, v.ld, v.dst, v.jmp, v.mreq, v.rdy);
  endtask

  // Check one cycle at the falling edge, advance the counter model, move past the next rising edge.
  task automatic cycle(input logic [6:0] exp, input string name);
    @(negedge clk_i);
    chk({name, " ctl"}, 32'(ctl), 32'(exp));
    chk({name, " ctl4"}, 32'(ctl4), 32'(exp));
    chk({name, " stall_cnt"}, bus.stall_cnt_o, exp_stall);
    chk({name, " stall_cnt4"}, bus4.stall_cnt_o, exp_stall);
    chk({name, " flush_cnt"}, bus.flush_cnt_o, exp_flush);
    chk({name, " flush_cnt4"}, bus4.flush_cnt_o, exp_flush);
    chk({name, " timeout"}, 32'(bus.mem_timeout_o), 32'(exp_to));
    chk({name, " timeout4"}, 32'(bus4.mem_timeout_o), 32'(exp_to4));
    if (!rst) begin
      if (exp[6]) exp_stall++;
      if (exp[2]) exp_flush++;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"idle",         5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, C_IDLE};
    vecs[1]  = '{"lu rs2 x5",    5'd1,  5'd5,  1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, C_LU};
    vecs[2]  = '{"load x0",      5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_IDLE};
    vecs[3]  = '{"rs2 unused",   5'd1,  5'd5,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, C_IDLE};
    vecs[4]  = '{"lu rs1 x7",    5'd7,  5'd2,  1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, C_LU};
    vecs[5]  = '{"no load",      5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0, C_IDLE};
    vecs[6]  = '{"jmp over lu",  5'd3,  5'd0,  1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, C_RD};
    vecs[7]  = '{"jmp",          5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, C_RD};
    vecs[8]  = '{"mem rdy lu",   5'd9,  5'd9,  1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1, C_LU};
    vecs[9]  = '{"jmp rdy low",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, C_RD};
    vecs[10] = '{"lu via rs2",   5'd12, 5'd4,  1'b1, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, C_LU};
    vecs[11] = '{"no match",     5'd30, 5'd29, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, C_IDLE};
    vecs[12] = '{"rs1 unused",   5'd8,  5'd3,  1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, C_IDLE};
    vecs[13] = '{"mem rdy jmp",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, C_RD};

    // Reset state: bubbles high, stalls and counters clear.
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(C_RST, "reset");
    rst = 1'b0;

    // Single-cycle hazard table, all in RUN.
    foreach (vecs[i]) begin
      drive_vec(vecs[i]);
      cycle(vecs[i].exp, vecs[i].name);
    end

    // Memory wait of 3 cycles masking redirect and load-use; release on the 4th.
    drv(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cycle(C_MS, "mwait c1");
    cycle(C_MS, "mwait c2");
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(C_MS, "mwait c3 noreq");
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle(C_IDLE, "mwait release");
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(C_IDLE, "back in run");

    // TIMEOUT=4 instance: flag rises on the 5th waiting cycle and sticks.
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      exp_to4 = (k >= 6);
      cycle(C_MS, "tmo4 wait");
    end
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle(C_IDLE, "tmo4 release");
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(C_IDLE, "tmo4 sticky");

    // Default TIMEOUT=255: flag rises on the 256th waiting cycle.
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 258; k++) begin
      exp_to = (k >= 257);
      cycle(C_MS, "tmo255 wait");
    end
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(C_IDLE, "tmo255 release");

    // Reset during the 2nd waiting cycle aborts the wait and clears everything.
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle(C_MS, "rst mwait c1");
    @(negedge clk_i);
    chk("rst mwait c2 ctl", 32'(ctl), 32'(C_MS));
    #1;
    rst       = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
    exp_to    = 1'b0;
    exp_to4   = 1'b0;
    #1;
    chk("async rst ctl", 32'(ctl), 32'(C_RST));
    chk("async rst stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("async rst flush_cnt", bus.flush_cnt_o, 32'd0);
    chk("async rst timeout", 32'(bus.mem_timeout_o), 32'd0);
    chk("async rst timeout4", 32'(bus4.mem_timeout_o), 32'd0);
    @(posedge clk_i);
    #1;
    drv(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    cycle(C_RST, "held rst");
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(C_IDLE, "post rst run");
    drv(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle(C_LU, "post rst lu");
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle(C_RD, "post rst jmp");
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(C_IDLE, "final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
